pc_sequencer: RTL and testbench

Next-address controller for the fetch-stage program counter. Each cycle it chooses the value and write-enable the PC loads: sequential PC+4, branch target, jump target, exception vector or exception return. It arbitrates these sources against pipeline stalls and holds a redirect that arrives during a stall until the stall clears. It sits between the hazard/branch logic and the PC register and drives that register's `addr` and `PC_Write` inputs.

---
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address controller for the fetch-stage PC register.
// Picks the next PC among reset, sequential, branch, jump, exception and
// exception-return sources. A redirect that arrives during a stall is held
// until the stall clears. All outputs are registered.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] addr,
    output logic [2:0]  PC_Write,
    output logic        flush,
    output logic        pending,
    output logic [31:0] epc
);

    localparam int unsigned AW  = 32;
    localparam int unsigned PWW = 3;

    localparam logic [PWW-1:0] PCW_LOAD = 3'b111;
    localparam logic [PWW-1:0] PCW_HOLD = 3'b000;
    localparam logic [AW-1:0]  PC_STEP  = 32'd4;
    localparam logic [AW-1:0]  ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_EXC  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [PWW-1:0] pcw_q, pcw_d;
    logic           flush_q, flush_d;
    logic           pending_q, pending_d;
    logic [AW-1:0]  epc_q, epc_d;
    logic [AW-1:0]  tgt_q, tgt_d;

    logic           redir_req;
    logic [AW-1:0]  redir_tgt;
    logic [AW-1:0]  seq_addr;

    // Highest-priority non-exception redirect: eret > branch > jump, word-aligned.
    always_comb begin
        redir_req = eret | br_valid | jmp_valid;
        if (eret) begin
            redir_tgt = epc_q & ALIGN_MASK;
        end else if (br_valid) begin
            redir_tgt = br_target & ALIGN_MASK;
        end else begin
            redir_tgt = jmp_target & ALIGN_MASK;
        end
        seq_addr = AW'(pc + PC_STEP);
    end

    // Next-state and next-output selection.
    always_comb begin
        state_d   = state_q;
        addr_d    = pc;
        pcw_d     = PCW_HOLD;
        flush_d   = 1'b0;
        pending_d = pending_q;
        epc_d     = epc_q;
        tgt_d     = tgt_q;

        case (state_q)
            ST_BOOT: begin
                addr_d  = RESET_VECTOR;
                pcw_d   = PCW_LOAD;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (exc_req) begin
                    addr_d    = EXC_VECTOR;
                    pcw_d     = PCW_LOAD;
                    flush_d   = 1'b1;
                    epc_d     = pc;
                    pending_d = 1'b0;
                    state_d   = ST_EXC;
                end else if (redir_req) begin
                    if (stall) begin
                        tgt_d     = redir_tgt;
                        pending_d = 1'b1;
                        state_d   = ST_PEND;
                    end else begin
                        addr_d  = redir_tgt;
                        pcw_d   = PCW_LOAD;
                        flush_d = 1'b1;
                    end
                end else if (!stall) begin
                    addr_d = seq_addr;
                    pcw_d  = PCW_LOAD;
                end
            end

            ST_PEND: begin
                // The first held redirect wins; newer redirects are dropped.
                if (exc_req) begin
                    addr_d    = EXC_VECTOR;
                    pcw_d     = PCW_LOAD;
                    flush_d   = 1'b1;
                    epc_d     = pc;
                    pending_d = 1'b0;
                    tgt_d     = '0;
                    state_d   = ST_EXC;
                end else if (!stall) begin
                    addr_d    = tgt_q;
                    pcw_d     = PCW_LOAD;
                    flush_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end

            ST_EXC: begin
                // Drain cycle: keep the IF/ID stage killed, ignore requests.
                flush_d = 1'b1;
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_BOOT;
            addr_q    <= RESET_VECTOR;
            pcw_q     <= PCW_HOLD;
            flush_q   <= 1'b0;
            pending_q <= 1'b0;
            epc_q     <= '0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pcw_q     <= pcw_d;
            flush_q   <= flush_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            tgt_q     <= tgt_d;
        end
    end

    assign addr     = addr_q;
    assign PC_Write = pcw_q;
    assign flush    = flush_q;
    assign pending  = pending_q;
    assign epc      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_3000;
    localparam logic [31:0] EV = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] addr;
    logic [2:0]  PC_Write;
    logic        flush;
    logic        pending;
    logic [31:0] epc;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .addr       (addr),
        .PC_Write   (PC_Write),
        .flush      (flush),
        .pending    (pending),
        .epc        (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a "booting" flag, a "draining" flag and a one-entry
    // queue of held redirect targets, stepped from the sampled inputs.
    bit          m_boot;
    bit          m_drain;
    logic [31:0] m_held[$];
    logic [31:0] m_epc;
    logic [31:0] e_addr;
    logic [2:0]  e_pcw;
    logic        e_flush;
    logic        e_pend;
    logic [31:0] e_epc;

    always @(posedge clk or negedge reset) begin
        logic [31:0] t;
        if (!reset) begin
            m_boot  = 1; m_drain = 0; m_held.delete(); m_epc = 0;
            e_addr  = RV; e_pcw = 3'b000; e_flush = 0;
        end else begin
            e_addr = pc; e_pcw = 3'b000; e_flush = 0;
            if (m_boot) begin
                e_addr = RV; e_pcw = 3'b111; m_boot = 0;
            end else if (m_drain) begin
                e_flush = 1; m_drain = 0;
            end else if (exc_req) begin
                e_addr = EV; e_pcw = 3'b111; e_flush = 1;
                m_epc = pc; m_held.delete(); m_drain = 1;
            end else if (m_held.size() != 0) begin
                if (!stall) begin
                    e_addr = m_held.pop_front(); e_pcw = 3'b111; e_flush = 1;
                end
            end else if (eret || br_valid || jmp_valid) begin
                t = eret ? m_epc : (br_valid ? br_target : jmp_target);
                t = {t[31:2], 2'b00};
                if (stall) m_held.push_back(t);
                else begin
                    e_addr = t; e_pcw = 3'b111; e_flush = 1;
                end
            end else if (!stall) begin
                e_addr = pc + 32'd4; e_pcw = 3'b111;
            end
        end
        e_pend = (m_held.size() != 0);
        e_epc  = m_epc;
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("addr",     addr,             e_addr);
            chk("PC_Write", 32'(PC_Write),    32'(e_pcw));
            chk("flush",    32'(flush),       32'(e_flush));
            chk("pending",  32'(pending),     32'(e_pend));
            chk("epc",      epc,              e_epc);
        end
    end

    task automatic clr();
        stall = 0; br_valid = 0; jmp_valid = 0; exc_req = 0; eret = 0;
    endtask

    // Advance one clock; inputs set afterwards land 2 time units past the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; pc = 0; br_target = 0; jmp_target = 0; clr();
        #1 reset = 0;
        #1;
        chk("rst_addr",    addr, RV);
        chk("rst_pcw",     32'(PC_Write), 32'd0);
        chk("rst_flush",   32'(flush), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_epc",     epc, 32'd0);
        chk_en = 1;
        tick(); tick();

        // Boot
        reset = 1; pc = 32'h0;
        tick();
        chk("boot_addr", addr, 32'h3000);
        chk("boot_pcw",  32'(PC_Write), 32'h7);
        pc = 32'h3000;
        tick();
        chk("seq_addr", addr, 32'h3004);
        chk("seq_pcw",  32'(PC_Write), 32'h7);

        // Branch beats jump, target aligned
        pc = 32'h3010; br_valid = 1; br_target = 32'h3403; jmp_valid = 1; jmp_target = 32'h5000;
        tick();
        chk("br_addr",  addr, 32'h3400);
        chk("br_flush", 32'(flush), 32'd1);
        clr(); pc = 32'h3400;
        tick();
        chk("br_flush_once", 32'(flush), 32'd0);

        // Stalled jump then branch: the first held redirect wins
        pc = 32'h3404; stall = 1; jmp_valid = 1; jmp_target = 32'h3100;
        tick();
        chk("st1_pend", 32'(pending), 32'd1);
        chk("st1_pcw",  32'(PC_Write), 32'd0);
        jmp_valid = 0; br_valid = 1; br_target = 32'h3200;
        tick();
        br_valid = 0;
        tick();
        chk("st3_pend", 32'(pending), 32'd1);
        stall = 0;
        tick();
        chk("rel_addr",  addr, 32'h3100);
        chk("rel_flush", 32'(flush), 32'd1);
        chk("rel_pend",  32'(pending), 32'd0);

        // Exception during PEND, then eret
        pc = 32'h3100; stall = 1; br_valid = 1; br_target = 32'h3300;
        tick();
        br_valid = 0; pc = 32'h3008; exc_req = 1;
        tick();
        chk("exc_addr",  addr, EV);
        chk("exc_epc",   epc, 32'h3008);
        chk("exc_pend",  32'(pending), 32'd0);
        chk("exc_flush", 32'(flush), 32'd1);
        clr(); stall = 1; pc = 32'h3008;
        tick();
        chk("drain_flush", 32'(flush), 32'd1);
        chk("drain_pcw",   32'(PC_Write), 32'd0);
        stall = 0; pc = EV;
        tick();
        chk("post_exc_addr", addr, 32'h4184);
        pc = 32'h4184; eret = 1;
        tick();
        chk("eret_addr", addr, 32'h3008);

        // Simultaneous exception and eret; unaligned epc returns aligned
        pc = 32'h3502; exc_req = 1; eret = 1;
        tick();
        chk("sim_addr", addr, EV);
        chk("sim_epc",  epc, 32'h3502);
        clr(); pc = EV;
        tick();
        eret = 1; pc = 32'h4180;
        tick();
        chk("eret_align", addr, 32'h3500);
        clr();

        // Wrap
        pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", addr, 32'h0);
        chk("wrap_pcw",  32'(PC_Write), 32'h7);

        // Async reset in PEND
        pc = 32'h3600; stall = 1; jmp_valid = 1; jmp_target = 32'h3700;
        tick();
        chk("pre_rst_pend", 32'(pending), 32'd1);
        reset = 0;
        #1;
        chk("arst_addr", addr, RV);
        chk("arst_pcw",  32'(PC_Write), 32'd0);
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_epc",  epc, 32'd0);
        tick();
        clr(); reset = 1; pc = 32'h0;
        tick();
        chk("reboot_addr", addr, RV);
        pc = RV;
        tick();
        chk("reboot_seq",  addr, 32'h3004);
        chk("reboot_pend", 32'(pending), 32'd0);
        tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
